loop_iter_profiler: RTL and testbench
=====================================

Name: loop_iter_profiler

Overview:
- Synthesizable per-loop activity profiler. It sits directly upstream of the simulation dataflow/loop-status dump stage.
- Taps one HLS pipelined loop's handshake and iteration strobes (ap_start/ap_ready/ap_done_int, iteration start/end qualifiers).
- Condenses each loop transaction into one fixed-width record: cycles, iterations, stall cycles, optional worst inter-iteration gap.
- Records are buffered in a small FIFO and drained over a valid/ready port to the CSV dump stage, or to an on-chip trace reader in hardware builds.

Parameters:
- CNT_W, 32, width of every counter field; counters saturate at 2^CNT_W-1.
- DEPTH, 4, record FIFO depth; power of two, ≥2.
- ID_W, 4, width of the static loop identifier carried in each record.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- loop_id  in  ID_W  static loop identifier, copied into each record.
- loop_start  in  1  loop ap_start.
- loop_done  in  1  loop ap_done_int.
- iter_start  in  1  pre-qualified strobe: (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block.
- iter_end  in  1  pre-qualified strobe: the same qualification using the end-state signals.
- stall  in  1  pp0 stage0 subdone block.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_data  out  ID_W+3*CNT_W(+CNT_W)  packed as {id, cycles, iters, stalls[, max_gap]}, MSB first.
- drop_cnt  out  CNT_W  records lost because the FIFO was full; saturating.
- busy  out  1  a transaction is in progress.

Behaviour:
- Reset (asynchronous, ap_rst_n low):
  - rec_valid=0, rec_data=0, drop_cnt=0, busy=0.
  - FIFO emptied, FSM forced to IDLE, all accumulators cleared.
  - An in-flight transaction is discarded with no record.
- FSM states: IDLE, RUN, COMMIT.
- IDLE:
  - loop_start=1 → RUN on the next edge, busy=1.
  - cycles=1; iters and stalls are loaded with the current-cycle values of iter_end and stall.
- RUN, every cycle:
  - cycles+=1.
  - stalls+=stall.
  - iters+=iter_end.
  - gap counter increments and resets to 0 on iter_start.
  - max_gap=max(max_gap, gap) when iter_start fires.
- RUN exit:
  - loop_done=1 → COMMIT; that cycle's counts are included.
  - loop_done and loop_start in the same RUN cycle → COMMIT; the next transaction starts from IDLE only after COMMIT.
- COMMIT (exactly 1 cycle):
  - FIFO not full → push the record.
  - FIFO full → drop the record and increment drop_cnt.
  - Then IDLE, busy=0.
- Back-to-back: loop_start high in COMMIT is registered; the FSM goes straight to RUN with fresh counters, so no start is lost.
- Latency: the record is visible on rec_valid 2 cycles after the edge sampling loop_done=1 (COMMIT, then FIFO output register).
- Output handshake:
  - A record transfers when rec_valid & rec_ready.
  - rec_data is held stable while rec_valid=1 and rec_ready=0.
  - Push and pop in the same cycle when full is legal: the pop frees the slot, so no drop.
- Full/empty and pointers:
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
  - Empty → rec_valid=0; rec_data holds its last value.
- Saturation: every counter sticks at its maximum; no wrap.
- Spurious strobes: iter_start, iter_end and stall are ignored in IDLE.

Optional Feature:
- Macro: LOOP_ITER_PROFILER_MAXGAP_EN.
- Defined: max_gap tracking is built in and rec_data has 4 fields, width ID_W+4*CNT_W.
- Undefined: the gap logic is absent and rec_data is ID_W+3*CNT_W.
- Every other behaviour is identical in both builds.

Decomposition:
- Package loop_prof_pkg:
  - state enum {IDLE,RUN,COMMIT};
  - record struct typedef, with the field conditional on the macro;
  - saturating-increment function;
  - REC_W localparam helper.
- One sub-module, loop_prof_fifo: synchronous FIFO with registered output, parameterized by DEPTH and width.

Test Plan:
1. Start pulse, then 10 iter_end strobes, no stall, done on cycle 12 → one record {id, cycles=12, iters=10, stalls=0}, rec_valid 2 cycles after done.
2. Same transaction with stall held high for 3 cycles mid-run → stalls=3 and cycles=15.
3. rec_ready=0 and 5 transactions with DEPTH=4 → 4 records queued, drop_cnt=1; draining returns them in order with stable data under backpressure.
4. loop_start high in the COMMIT cycle of transaction A → transaction B is counted from that cycle; both records are correct and none is dropped.
5. ap_rst_n asserted asynchronously mid-RUN with 2 records queued → all outputs are 0 immediately; after release, a new transaction yields a clean record.
6. MAXGAP build: iter_start gaps of 1,1,4,1 cycles → max_gap=4; CNT_W=4 and a run of >15 cycles → cycles saturates at 15.

Source files
------------

// File: rtl/loop_prof_pkg.sv
// Shared types and helpers for the per-loop activity profiler.
// Build option LOOP_ITER_PROFILER_MAXGAP_EN adds a worst inter-iteration gap field to each record.
package loop_prof_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

`ifdef LOOP_ITER_PROFILER_MAXGAP_EN
    localparam int unsigned REC_FIELDS = 4;
`else
    localparam int unsigned REC_FIELDS = 3;
`endif

    // Record layout at the default widths, for consumers that unpack rec_data.
    localparam int unsigned DEF_ID_W  = 4;
    localparam int unsigned DEF_CNT_W = 32;

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_CNT_W-1:0] cycles;
        logic [DEF_CNT_W-1:0] iters;
        logic [DEF_CNT_W-1:0] stalls;
`ifdef LOOP_ITER_PROFILER_MAXGAP_EN
        logic [DEF_CNT_W-1:0] max_gap;
`endif
    } rec_t;

    function automatic int unsigned rec_w(input int unsigned id_w, input int unsigned cnt_w);
        return id_w + REC_FIELDS * cnt_w;
    endfunction

    // Adds inc to val but never past the largest w-bit value.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic inc,
                                            input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (inc && (val < max_v)) ? (val + 64'd1) : val;
    endfunction

endpackage

// File: rtl/loop_prof_fifo.sv
// Record FIFO with a registered head: a pushed entry reaches out_valid/out_data one cycle after
// its write. Total capacity is DEPTH including the displayed head entry.
module loop_prof_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             pop;
    logic             push;

    // A pop in the same cycle frees the head slot, so a push while full is still accepted.
    always_comb begin
        pop      = valid_q & out_ready;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        in_ready = ~full | pop;
        push     = in_valid & in_ready;
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        valid_d  = (wr_ptr_q != rd_ptr_d);
        data_d   = data_q;
        if (valid_d) begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/loop_iter_profiler.sv
// Per-loop activity profiler: condenses each loop transaction into one record and queues it.
// Define LOOP_ITER_PROFILER_MAXGAP_EN to add worst inter-iteration gap tracking.
module loop_iter_profiler
    import loop_prof_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [ID_W-1:0]               loop_id,
    input  logic                          loop_start,
    input  logic                          loop_done,
    input  logic                          iter_start,
    input  logic                          iter_end,
    input  logic                          stall,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [rec_w(ID_W, CNT_W)-1:0] rec_data,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          busy,
    output state_t                        dbg_state
);
    localparam int REC_W = int'(rec_w(ID_W, CNT_W));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] iters_q, iters_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             start_load;
    logic             commit;
    logic             fifo_in_ready;
    logic [REC_W-1:0] rec_in;

    // A start is honoured from IDLE and from COMMIT, so back-to-back transactions lose nothing.
    assign start_load = loop_start && ((state_q == IDLE) || (state_q == COMMIT));
    assign commit     = (state_q == COMMIT);

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        iters_d  = iters_q;
        stalls_d = stalls_q;
        drop_d   = drop_q;
        unique case (state_q)
            IDLE: begin
                if (loop_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cycles_d = CNT_W'(sat_inc(64'(cycles_q), 1'b1, CNT_W));
                iters_d  = CNT_W'(sat_inc(64'(iters_q), iter_end, CNT_W));
                stalls_d = CNT_W'(sat_inc(64'(stalls_q), stall, CNT_W));
                if (loop_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = loop_start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The start cycle itself is cycle 1 and contributes its own strobes.
        if (start_load) begin
            cycles_d = CNT_W'(1);
            iters_d  = CNT_W'(iter_end);
            stalls_d = CNT_W'(stall);
        end
        if (commit && !fifo_in_ready) begin
            drop_d = CNT_W'(sat_inc(64'(drop_q), 1'b1, CNT_W));
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            cycles_q <= '0;
            iters_q  <= '0;
            stalls_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            iters_q  <= iters_d;
            stalls_q <= stalls_d;
            drop_q   <= drop_d;
        end
    end

`ifdef LOOP_ITER_PROFILER_MAXGAP_EN
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] max_gap_q, max_gap_d;
    logic [CNT_W-1:0] gap_inc;

    // gap_inc is the distance in cycles to the previous iter_start (or to the start cycle).
    always_comb begin
        gap_d     = gap_q;
        max_gap_d = max_gap_q;
        gap_inc   = CNT_W'(sat_inc(64'(gap_q), 1'b1, CNT_W));
        if (start_load) begin
            gap_d     = '0;
            max_gap_d = '0;
        end else if (state_q == RUN) begin
            if (iter_start) begin
                gap_d = '0;
                if (gap_inc > max_gap_q) begin
                    max_gap_d = gap_inc;
                end
            end else begin
                gap_d = gap_inc;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gap_q     <= '0;
            max_gap_q <= '0;
        end else begin
            gap_q     <= gap_d;
            max_gap_q <= max_gap_d;
        end
    end

    assign rec_in = {loop_id, cycles_q, iters_q, stalls_q, max_gap_q};
`else
    logic gap_unused;
    assign gap_unused = iter_start;
    assign rec_in     = {loop_id, cycles_q, iters_q, stalls_q};
`endif

    loop_prof_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (commit),
        .in_ready  (fifo_in_ready),
        .in_data   (rec_in),
        .out_valid (rec_valid),
        .out_ready (rec_ready),
        .out_data  (rec_data)
    );

    assign drop_cnt  = drop_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_loop_iter_profiler.sv
// Randomized bench for loop_iter_profiler: per-transaction records are predicted from the
// stimulus arrays and compared in order on the output handshake.
module tb_loop_iter_profiler;
    import loop_prof_pkg::*;

    localparam int CNT_W   = 32;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int S_CNT_W = 4;
    localparam int S_DEPTH = 2;
`ifdef LOOP_ITER_PROFILER_MAXGAP_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif
    localparam int REC_W   = ID_W + NF * CNT_W;
    localparam int S_REC_W = ID_W + NF * S_CNT_W;

    // ---------------- clock / reset ----------------
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [ID_W-1:0]    loop_id     = '0;
    logic               loop_start  = 1'b0;
    logic               loop_done   = 1'b0;
    logic               iter_start  = 1'b0;
    logic               iter_end    = 1'b0;
    logic               stall       = 1'b0;
    logic               rec_ready   = 1'b1;
    logic               s_rec_ready = 1'b1;
    logic               rec_valid, s_rec_valid;
    logic [REC_W-1:0]   rec_data;
    logic [S_REC_W-1:0] s_rec_data;
    logic [CNT_W-1:0]   drop_cnt;
    logic [S_CNT_W-1:0] s_drop_cnt;
    logic               busy, s_busy;
    state_t             dbg_state, s_dbg_state;

    loop_iter_profiler #(.CNT_W(CNT_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .loop_id(loop_id), .loop_start(loop_start),
        .loop_done(loop_done), .iter_start(iter_start), .iter_end(iter_end), .stall(stall),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .drop_cnt(drop_cnt), .busy(busy), .dbg_state(dbg_state)
    );

    loop_iter_profiler #(.CNT_W(S_CNT_W), .DEPTH(S_DEPTH), .ID_W(ID_W)) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .loop_id(loop_id), .loop_start(loop_start),
        .loop_done(loop_done), .iter_start(iter_start), .iter_end(iter_end), .stall(stall),
        .rec_valid(s_rec_valid), .rec_ready(s_rec_ready), .rec_data(s_rec_data),
        .drop_cnt(s_drop_cnt), .busy(s_busy), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int drop_exp = 0;
    logic [REC_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Current transaction script: index 0 is the start cycle, index len-1 the done cycle.
    int len;
    bit te[64];
    bit ts[64];
    bit sv[64];
    bit rs[64];

    function automatic longint unsigned clip(input longint unsigned v, input longint unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

    // Record from first principles: cycle count, strobe sums, and the largest distance between
    // successive iter_start pulses in the run cycles, measured from the start cycle initially.
    function automatic logic [159:0] model_rec(input logic [ID_W-1:0] id, input int cw);
        longint unsigned lim, c, it, st, mg, prev;
        logic [159:0] r;
        lim  = (64'd1 << cw) - 64'd1;
        c    = longint'(len);
        it   = 0;
        st   = 0;
        mg   = 0;
        prev = 0;
        for (int i = 0; i < len; i++) begin
            it += longint'(te[i]);
            st += longint'(sv[i]);
            if (i > 0 && ts[i]) begin
                if (longint'(i) - prev > mg) mg = longint'(i) - prev;
                prev = longint'(i);
            end
        end
        r = 160'(id);
        r = (r << cw) | 160'(clip(c, lim));
        r = (r << cw) | 160'(clip(it, lim));
        r = (r << cw) | 160'(clip(st, lim));
`ifdef LOOP_ITER_PROFILER_MAXGAP_EN
        r = (r << cw) | 160'(clip(mg, lim));
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_txn(input int n);
        len = n;
        for (int i = 0; i < 64; i++) begin
            te[i] = 0; ts[i] = 0; sv[i] = 0; rs[i] = 0;
        end
    endtask

    task automatic gen_txn(input int lo, input int hi, input int p_it, input int p_st,
                           input bit noise);
        clear_txn($urandom_range(hi, lo));
        for (int i = 0; i < len; i++) begin
            te[i] = ($urandom_range(99, 0) < p_it);
            ts[i] = ($urandom_range(99, 0) < p_it);
            sv[i] = ($urandom_range(99, 0) < p_st);
            rs[i] = noise && ($urandom_range(3, 0) == 0);
        end
    endtask

    task automatic push_expect();
        if (exp_q.size() >= DEPTH) drop_exp++;
        else exp_q.push_back(REC_W'(model_rec(loop_id, CNT_W)));
    endtask

    task automatic drive_txn();
        for (int i = 0; i < len; i++) begin
            loop_start = (i == 0) ? 1'b1 : rs[i];
            loop_done  = (i == len - 1);
            iter_start = ts[i];
            iter_end   = te[i];
            stall      = sv[i];
            step();
        end
        push_expect();
        loop_start = 0; loop_done = 0; iter_start = 0; iter_end = 0; stall = 0;
    endtask

    // Idle cycles with noise on every strobe except loop_start; the id changes only after the
    // first idle cycle so a pending COMMIT still records the previous id.
    task automatic drive_idle(input int n);
        for (int k = 0; k < n; k++) begin
            loop_start = 0;
            loop_done  = 1'($urandom_range(1, 0));
            iter_start = 1'($urandom_range(1, 0));
            iter_end   = 1'($urandom_range(1, 0));
            stall      = 1'($urandom_range(1, 0));
            if (k >= 1) loop_id = ID_W'($urandom_range(15, 0));
            step();
        end
        loop_done = 0; iter_start = 0; iter_end = 0; stall = 0;
    endtask

    task automatic wait_drain(input bit rnd_ready);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            if (rnd_ready) rec_ready = 1'($urandom_range(1, 0));
            step();
            cyc++;
        end
        rec_ready = 1'b1;
        check("drain_complete", 160'(exp_q.size()), 160'(0));
        repeat (3) step();
    endtask

    // ---------------- output monitor ----------------
    logic [REC_W-1:0] held;
    bit               hold_pending = 0;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending && rec_valid) check("hold_stable", 160'(rec_data), 160'(held));
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) check("unexpected_rec", 160'(rec_valid), 160'(0));
                else check("rec", 160'(rec_data), 160'(exp_q.pop_front()));
            end
            hold_pending = rec_valid && !rec_ready;
            held         = rec_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_valid", 160'(rec_valid), 160'(0));
        check("rst_data", 160'(rec_data), 160'(0));
        check("rst_drop", 160'(drop_cnt), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_state", 160'(dbg_state), 160'(IDLE));
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();

        // 12-cycle transaction with 10 iterations, plus latency and busy timing
        loop_id = 4'h5;
        clear_txn(12);
        for (int i = 1; i <= 10; i++) te[i] = 1;
        drive_txn();
        @(negedge ap_clk);
        check("lat_commit_valid", 160'(rec_valid), 160'(0));
        check("commit_busy", 160'(busy), 160'(1));
        @(negedge ap_clk);
        check("lat_plus1_valid", 160'(rec_valid), 160'(0));
        check("idle_busy", 160'(busy), 160'(0));
        @(negedge ap_clk);
        check("lat_plus2_valid", 160'(rec_valid), 160'(1));
        step();

        // Same shape with three stall cycles mid-run
        clear_txn(15);
        for (int i = 1; i <= 10; i++) te[i] = 1;
        for (int i = 6; i <= 8; i++) sv[i] = 1;
        drive_idle(2);
        drive_txn();
        drive_idle(2);
        wait_drain(0);

        // Random transactions, some back-to-back, with noise in idle and run cycles
        for (int n = 0; n < 25; n++) begin
            gen_txn(2, 30, 40, 30, 1);
            if ($urandom_range(3, 0) != 0) drive_idle($urandom_range(3, 1));
            drive_txn();
        end
        drive_idle(2);
        wait_drain(0);

        // Start in the COMMIT cycle of A: B counts from that cycle, nothing dropped
        loop_id = 4'h3;
        clear_txn(6);
        te[2] = 1; sv[3] = 1;
        drive_txn();
        clear_txn(8);
        te[0] = 1; sv[0] = 1; te[5] = 1;
        drive_txn();
        drive_idle(2);
        wait_drain(0);
        check("b2b_drop", 160'(drop_cnt), 160'(0));

        // Backpressure: five records into four slots
        rec_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            gen_txn(3, 12, 50, 20, 0);
            drive_idle(2);
            drive_txn();
        end
        drive_idle(3);
        check("bp_drop", 160'(drop_cnt), 160'(drop_exp));
        check("bp_drop_one", 160'(drop_cnt), 160'(1));
        check("bp_valid", 160'(rec_valid), 160'(1));
        wait_drain(1);
        check("bp_drop_after", 160'(drop_cnt), 160'(1));

        // Asynchronous reset mid-run with two records queued
        rec_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            gen_txn(4, 8, 50, 20, 0);
            drive_idle(1);
            drive_txn();
        end
        drive_idle(3);
        check("t5_queued", 160'(rec_valid), 160'(1));
        loop_start = 1'b1; iter_end = 1'b1;
        step();
        loop_start = 1'b0;
        repeat (3) step();
        check("t5_busy_run", 160'(busy), 160'(1));
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("arst_valid", 160'(rec_valid), 160'(0));
        check("arst_data", 160'(rec_data), 160'(0));
        check("arst_drop", 160'(drop_cnt), 160'(0));
        check("arst_busy", 160'(busy), 160'(0));
        iter_end = 1'b0;
        exp_q.delete();
        drop_exp = 0;
        step();
        step();
        ap_rst_n  = 1'b1;
        rec_ready = 1'b1;
        step();
        check("post_rst_state", 160'(dbg_state), 160'(IDLE));
        gen_txn(5, 15, 50, 30, 0);
        drive_idle(1);
        drive_txn();
        drive_idle(2);
        wait_drain(0);

        // Saturation on the narrow instance (every counter exceeds 15)
        loop_id = 4'hA;
        clear_txn(20);
        for (int i = 0; i < 20; i++) begin te[i] = 1; sv[i] = 1; end
        ts[19] = 1;
        drive_txn();
        @(negedge ap_clk);
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("sat_valid", 160'(s_rec_valid), 160'(1));
        check("sat_rec", 160'(s_rec_data), 160'(S_REC_W'(model_rec(loop_id, S_CNT_W))));
        check("sat_drop", 160'(s_drop_cnt), 160'(0));
        step();

        // Iteration starts spaced 1,1,1,4,1 cycles apart: worst gap 4
        clear_txn(10);
        ts[1] = 1; ts[2] = 1; ts[3] = 1; ts[7] = 1; ts[8] = 1;
        te[4] = 1; te[9] = 1;
        drive_idle(2);
        drive_txn();
        drive_idle(2);
        wait_drain(0);

        check("final_drop", 160'(drop_cnt), 160'(drop_exp));
        check("final_queue_empty", 160'(exp_q.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
